// File: rtl/rv32i_rom_loader.sv
// Boot loader: receives a length-prefixed byte frame from a host stream, writes
// it word by word into instruction memory and releases the core on a good checksum.
module rv32i_rom_loader #(
  parameter int ROM_DEPTH = 1024,
  parameter int AW        = $clog2(ROM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  input  logic          rearm,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [31:0]   wr_data,
  output logic          core_rst_n,
  output logic          done,
  output logic          error
);

  // state  | meaning
  // S_LEN0 | waiting for word count N[7:0]
  // S_LEN1 | waiting for word count N[15:8]; range-checks N
  // S_DATA | assembling little-endian words, one write per 4 bytes
  // S_CSUM | waiting for the XOR checksum byte
  // S_DONE | image good, core released from reset
  // S_ERR  | frame rejected, core held in reset
  typedef enum logic [2:0] {
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam int MAXW = ROM_DEPTH / 4;
  localparam int IW   = AW - 2;

  state_t          r_state;
  logic [15:0]     r_len;
  logic [IW-1:0]   r_widx;
  logic [1:0]      r_bcnt;
  logic [23:0]     r_word;
  logic [7:0]      r_csum;
  logic            r_rx_ready;
  logic            r_wr_en;
  logic [AW-1:0]   r_wr_addr;
  logic [31:0]     r_wr_data;
  logic            r_core_rst_n;
  logic            r_done;
  logic            r_error;

  logic            w_accept;
  logic [15:0]     w_n;
  logic            w_n_too_big;
  logic            w_last_word;
  logic [31:0]     w_word;

  assign w_accept    = rx_valid & r_rx_ready;
  assign w_n         = {rx_data, r_len[7:0]};
  assign w_n_too_big = ({16'd0, w_n} > 32'(MAXW));
  assign w_last_word = (16'(r_widx) == (r_len - 16'd1));
  assign w_word      = {rx_data, r_word};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_LEN0;
      r_len        <= 16'd0;
      r_widx       <= '0;
      r_bcnt       <= 2'd0;
      r_word       <= 24'd0;
      r_csum       <= 8'd0;
      r_rx_ready   <= 1'b1;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= 32'd0;
      r_core_rst_n <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        S_LEN0: begin
          if (w_accept) begin
            r_len[7:0] <= rx_data;
            r_state    <= S_LEN1;
          end
        end
        S_LEN1: begin
          if (w_accept) begin
            r_len[15:8] <= rx_data;
            if (w_n_too_big) begin
              r_state    <= S_ERR;
              r_error    <= 1'b1;
              r_rx_ready <= 1'b0;
            end else if (w_n == 16'd0) begin
              r_state <= S_CSUM;
            end else begin
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_csum <= r_csum ^ rx_data;
            r_bcnt <= r_bcnt + 2'd1;
            case (r_bcnt)
              2'd0: r_word[7:0]   <= rx_data;
              2'd1: r_word[15:8]  <= rx_data;
              2'd2: r_word[23:16] <= rx_data;
              default: begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= {r_widx, 2'b00};
                r_wr_data <= w_word;
                r_widx    <= r_widx + IW'(1);
                if (w_last_word) begin
                  r_state <= S_CSUM;
                end
              end
            endcase
          end
        end
        S_CSUM: begin
          if (w_accept) begin
            r_rx_ready <= 1'b0;
            if (rx_data == r_csum) begin
              r_state      <= S_DONE;
              r_done       <= 1'b1;
              r_core_rst_n <= 1'b1;
            end else begin
              r_state <= S_ERR;
              r_error <= 1'b1;
            end
          end
        end
        S_DONE, S_ERR: begin
          if (rearm) begin
            r_state      <= S_LEN0;
            r_len        <= 16'd0;
            r_widx       <= '0;
            r_bcnt       <= 2'd0;
            r_word       <= 24'd0;
            r_csum       <= 8'd0;
            r_rx_ready   <= 1'b1;
            r_core_rst_n <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
          end
        end
        default: begin
          r_state <= S_LEN0;
        end
      endcase
    end
  end

  assign rx_ready   = r_rx_ready;
  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign core_rst_n = r_core_rst_n;
  assign done       = r_done;
  assign error      = r_error;

endmodule

// File: tb/tb_rv32i_rom_loader.sv
// Directed bench for rv32i_rom_loader: good/bad checksum, oversize and empty
// frames, rearm, throttled streaming and asynchronous reset mid-load.
module tb_rv32i_rom_loader;

  localparam int AW = 10;

  logic          clk;
  logic          rst_n;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          rearm;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          core_rst_n;
  logic          done;
  logic          error;

  rv32i_rom_loader #(.ROM_DEPTH(1024), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rearm      (rearm),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .core_rst_n (core_rst_n),
    .done       (done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // write log, filled only by the monitor
  logic [31:0] wa [64];
  logic [31:0] wd [64];
  int          wcnt   = 0;
  int          consec = 0;
  logic        prev_we = 1'b0;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (wcnt < 64) begin
        wa[wcnt] = 32'(wr_addr);
        wd[wcnt] = wr_data;
      end
      wcnt++;
      if (prev_we) consec++;
    end
    prev_we = (wr_en === 1'b1);
  end

  logic [31:0] img [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // caller is at a negedge; returns at the negedge after the accepting edge
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic gap(input int n);
    rx_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      rx_data = 8'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic pulse_rearm();
    rearm = 1'b1;
    @(negedge clk);
    rearm = 1'b0;
  endtask

  task automatic send_words(input int n, input int maxgap);
    for (int w = 0; w < n; w++) begin
      for (int b = 0; b < 4; b++) begin
        send(img[w][8*b +: 8]);
        if (maxgap > 0) gap($urandom_range(1, maxgap));
      end
    end
  endtask

  task automatic chk_writes(input string tag, input int base, input int n);
    chk({tag, "_count"}, 32'(wcnt - base), 32'(n));
    for (int i = 0; i < n; i++) begin
      chk({tag, "_addr"}, wa[base + i], 32'(4 * i));
      chk({tag, "_data"}, wd[base + i], img[i]);
    end
  endtask

  int base;
  int cbase;

  initial begin
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'd0;
    rearm    = 1'b0;
    img[0] = 32'h0000_0013;
    img[1] = 32'h0010_0093;
    img[2] = 32'hDEAD_BEEF;
    img[3] = 32'h1234_5678;

    repeat (2) @(negedge clk);
    chk("rst_rx_ready",   32'(rx_ready),   32'd1);
    chk("rst_wr_en",      32'(wr_en),      32'd0);
    chk("rst_wr_addr",    32'(wr_addr),    32'd0);
    chk("rst_wr_data",    wr_data,         32'd0);
    chk("rst_core_rst_n", 32'(core_rst_n), 32'd0);
    chk("rst_done",       32'(done),       32'd0);
    chk("rst_error",      32'(error),      32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // N=2, XOR of 13 00 00 00 93 00 10 00 is 0x90
    base = wcnt;
    send(8'h02); send(8'h00);
    send_words(2, 0);
    chk("t1_core_rst_n_low_in_csum", 32'(core_rst_n), 32'd0);
    send(8'h90);
    chk_writes("t1", base, 2);
    chk("t1_done",       32'(done),       32'd1);
    chk("t1_core_rst_n", 32'(core_rst_n), 32'd1);
    chk("t1_error",      32'(error),      32'd0);
    chk("t1_rx_ready",   32'(rx_ready),   32'd0);
    pulse_rearm();
    chk("t1_rearm_done",  32'(done),       32'd0);
    chk("t1_rearm_core",  32'(core_rst_n), 32'd0);
    chk("t1_rearm_ready", 32'(rx_ready),   32'd1);

    // same frame, wrong checksum
    base = wcnt;
    send(8'h02); send(8'h00);
    send_words(2, 0);
    send(8'h81);
    chk_writes("t2", base, 2);
    chk("t2_error",      32'(error),      32'd1);
    chk("t2_done",       32'(done),       32'd0);
    chk("t2_core_rst_n", 32'(core_rst_n), 32'd0);
    chk("t2_rx_ready",   32'(rx_ready),   32'd0);
    pulse_rearm();
    chk("t2_rearm_error", 32'(error), 32'd0);

    // N=0x0101 exceeds 256 words; trailing bytes must be refused
    base = wcnt;
    send(8'h01); send(8'h01);
    chk("t3_error", 32'(error), 32'd1);
    send(8'h13); send(8'h00); send(8'h00); send(8'h00); send(8'h13);
    gap(2);
    chk("t3_no_write", 32'(wcnt - base), 32'd0);
    chk("t3_error_hold", 32'(error), 32'd1);
    chk("t3_rx_ready",   32'(rx_ready), 32'd0);
    pulse_rearm();

    // N=0, checksum 0x00
    base = wcnt;
    send(8'h00); send(8'h00); send(8'h00);
    chk("t4_done",     32'(done),       32'd1);
    chk("t4_core",     32'(core_rst_n), 32'd1);
    chk("t4_no_write", 32'(wcnt - base), 32'd0);
    pulse_rearm();
    chk("t4_rearm_done", 32'(done),       32'd0);
    chk("t4_rearm_core", 32'(core_rst_n), 32'd0);
    chk("t4_rearm_rdy",  32'(rx_ready),   32'd1);

    // N=4 back-to-back; a rearm pulse in LEN1 must be ignored. XOR = 0xBA
    base = wcnt;
    cbase = consec;
    send(8'h04);
    pulse_rearm();
    send(8'h00);
    send_words(4, 0);
    send(8'hBA);
    chk_writes("t5", base, 4);
    chk("t5_done", 32'(done), 32'd1);
    pulse_rearm();

    // same frame with random idle gaps between bytes
    base = wcnt;
    cbase = consec;
    send(8'h04); gap(2); send(8'h00); gap(1);
    send_words(4, 3);
    send(8'hBA);
    chk_writes("t6", base, 4);
    chk("t6_done",   32'(done),            32'd1);
    chk("t6_consec", 32'(consec - cbase),  32'd0);
    pulse_rearm();

    // async reset after 6 data bytes
    base = wcnt;
    send(8'h02); send(8'h00);
    for (int b = 0; b < 4; b++) send(img[0][8*b +: 8]);
    send(img[1][7:0]); send(img[1][15:8]);
    chk("t7_one_write", 32'(wcnt - base), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_rx_ready", 32'(rx_ready),   32'd1);
    chk("t7_wr_en",    32'(wr_en),      32'd0);
    chk("t7_wr_addr",  32'(wr_addr),    32'd0);
    chk("t7_wr_data",  wr_data,         32'd0);
    chk("t7_core",     32'(core_rst_n), 32'd0);
    chk("t7_done",     32'(done),       32'd0);
    chk("t7_error",    32'(error),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    base = wcnt;
    img[0] = 32'hDDCC_BBAA;
    send(8'h01); send(8'h00);
    send_words(1, 0);
    send(8'h00);
    chk_writes("t7_fresh", base, 1);
    chk("t7_fresh_done", 32'(done), 32'd1);

    gap(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
